// File: rtl/range_coalesce.sv
// range_coalesce
//   Coalesces a stream of inclusive [first, second] ID ranges that arrive
//   sorted ascending by first. Overlapping or adjacent ranges are merged into
//   one. Each disjoint merged range is emitted as a one-cycle pulse. Two
//   running totals are kept: the number of covered IDs and the number of
//   ranges emitted.
//
// Handshake: a pair is taken on any posedge where pair_valid_in and
//   pair_ready_out are both high. pair_ready_out depends only on the state
//   register, never on pair_valid_in. While pair_ready_out is low, the block
//   ignores pair_valid_in and the pair inputs.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   pair_valid_in        sorted pair presented this cycle
//   pair_ready_out       block accepts a pair this cycle (IDLE/ACCUM)
//   pair_first_in        range low bound  (DATA_WIDTH)
//   pair_second_in       range high bound (DATA_WIDTH)
//   stream_done_in       one-cycle pulse; no further pairs follow
//   range_valid_out      one-cycle pulse; merged range on range_*_out
//   range_first_out      merged range low bound
//   range_second_out     merged range high bound
//   total_count_out      running count of covered IDs (wraps mod 2^SUM_WIDTH)
//   range_count_out      number of merged ranges emitted
//   done_out             level; final results valid (state == DONE)
//   order_error_out      sticky input-order violation flag
//   state_dbg            current FSM state encoding, for observation
//
// Optional feature: define RC_ORDER_CHECK_EN to enable the order checker.
//   When it is undefined, order_error_out is tied to 0.

module range_coalesce #(
  parameter int DATA_WIDTH = 64,
  parameter int SUM_WIDTH  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pair_valid_in,
  output logic                  pair_ready_out,
  input  logic [DATA_WIDTH-1:0] pair_first_in,
  input  logic [DATA_WIDTH-1:0] pair_second_in,
  input  logic                  stream_done_in,
  output logic                  range_valid_out,
  output logic [DATA_WIDTH-1:0] range_first_out,
  output logic [DATA_WIDTH-1:0] range_second_out,
  output logic [SUM_WIDTH-1:0]  total_count_out,
  output logic [CNT_WIDTH-1:0]  range_count_out,
  output logic                  done_out,
  output logic                  order_error_out,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] cur_lo;
  logic [DATA_WIDTH-1:0] cur_hi;

  logic                  accept;
  logic [DATA_WIDTH:0]   hi_plus1;
  logic                  joinable;
  logic [DATA_WIDTH-1:0] merged_hi;
  logic [DATA_WIDTH:0]   span;
  logic [SUM_WIDTH-1:0]  span_ext;

  assign pair_ready_out = (state == IDLE) || (state == ACCUM);
  assign done_out       = (state == DONE);
  assign state_dbg      = state;
  assign accept         = pair_valid_in && pair_ready_out;

  // The adjacency test uses one extra bit. This keeps cur_hi = all-ones from
  // wrapping to 0 and reporting a false disjoint range.
  assign hi_plus1  = {1'b0, cur_hi} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign joinable  = ({1'b0, pair_first_in} <= hi_plus1);
  assign merged_hi = (pair_second_in > cur_hi) ? pair_second_in : cur_hi;

  // A full-width range holds 2^DATA_WIDTH IDs, so the span needs one extra
  // bit. It is then zero-extended or truncated to the accumulator width.
  assign span     = {1'b0, cur_hi} - {1'b0, cur_lo} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign span_ext = SUM_WIDTH'(span);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cur_lo           <= '0;
      cur_hi           <= '0;
      range_valid_out  <= 1'b0;
      range_first_out  <= '0;
      range_second_out <= '0;
      total_count_out  <= '0;
      range_count_out  <= '0;
    end else begin
      range_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_lo <= pair_first_in;
            cur_hi <= pair_second_in;
            state  <= stream_done_in ? FLUSH : ACCUM;
          end else if (stream_done_in) begin
            state <= DONE;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (joinable) begin
              cur_hi <= merged_hi;
            end else begin
              range_valid_out  <= 1'b1;
              range_first_out  <= cur_lo;
              range_second_out <= cur_hi;
              total_count_out  <= total_count_out + span_ext;
              range_count_out  <= range_count_out + CNT_WIDTH'(1);
              cur_lo           <= pair_first_in;
              cur_hi           <= pair_second_in;
            end
          end
          // A pair taken in the same cycle is merged or emitted first (above).
          // The range left in cur_lo/cur_hi is then flushed.
          if (stream_done_in) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          range_valid_out  <= 1'b1;
          range_first_out  <= cur_lo;
          range_second_out <= cur_hi;
          total_count_out  <= total_count_out + span_ext;
          range_count_out  <= range_count_out + CNT_WIDTH'(1);
          state            <= DONE;
        end
        DONE: begin
          // Terminal state: results are held until reset.
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RC_ORDER_CHECK_EN
  // The flag is sticky. A flagged pair is still merged or emitted normally.
  always_ff @(posedge clock) begin
    if (reset) begin
      order_error_out <= 1'b0;
    end else if (accept &&
                 ((pair_second_in < pair_first_in) ||
                  ((state == ACCUM) && (pair_first_in < cur_lo)))) begin
      order_error_out <= 1'b1;
    end
  end
`else
  assign order_error_out = 1'b0;
`endif

endmodule
